axil_dma_regs: RTL and testbench
================================

Name: axil_dma_regs

Overview:
AXI4-Lite slave register file implementing the simple-mode DMA control/status map (MM2S and S2MM channels). It sits directly downstream of the AXI-Lite master stimulus and consumes its CR/SR/address/length programming sequence. It issues per-channel start pulses with address and length to the DMA datapath, and returns per-channel interrupts on completion.

Parameters:
DATA_WIDTH, 32, AXI-Lite data width (fixed 32; other values unsupported)
ADDR_WIDTH, 32, AXI-Lite address width; only addr[7:0] decoded
LEN_WIDTH, 26, implemented bits of LENGTH registers (byte count)

Ports:
S_AXI_aclk  in  1  clock
S_AXI_aresetn  in  1  reset, asynchronous assert, active-low
S_AXI_awaddr/awprot/awvalid/awready  in/in/in/out  ADDR_WIDTH/3/1/1  write address channel (awprot ignored)
S_AXI_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel
S_AXI_bresp/bvalid/bready  out/out/in  2/1/1  write response
S_AXI_araddr/arprot/arvalid/arready  in/in/in/out  ADDR_WIDTH/3/1/1  read address (arprot ignored)
S_AXI_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data
mm2s_start  out  1  one-cycle pulse: launch MM2S transfer
mm2s_addr  out  64  {MM2S_SM, MM2S_SA}, stable while busy
mm2s_len  out  LEN_WIDTH  byte count, stable while busy
mm2s_done  in  1  one-cycle pulse from datapath: transfer complete
s2mm_start, s2mm_addr, s2mm_len, s2mm_done  same as above for S2MM ({S2MM_DM, S2MM_DA})
mm2s_introut, s2mm_introut  out  1  level interrupts

Behaviour:
- Reset: all registers 0; awready, wready, bvalid, arready, rvalid, start pulses, introuts = 0; bresp = rresp = 0; rdata = 0; both channels idle.
- Write handshake: awready and wready asserted together for exactly one cycle when awvalid and wvalid are both high and bvalid is 0. Register update occurs on that edge. bvalid is set the next cycle and held until bready; bresp = OKAY. Either valid alone never gets accepted.
- Read handshake: arready pulses one cycle when arvalid and not rvalid. rvalid/rdata are valid the following cycle and held until rready; rresp = OKAY.
- Byte lanes: wstrb gates each byte of writable fields. Unmapped offsets: writes dropped with OKAY; reads return 0.
- Map (per channel; MM2S base 0x00, S2MM base 0x30):
  - CR (+0x00): bit0 RS, bit12 IOC_IrqEn; other bits read 0.
  - SR (+0x04), read: bit0 Halted (= ~RS and idle), bit1 Idle, bit4 Err, bit12 IOC_Irq. Write: bit12 and bit4 are W1C; other bits read-only.
  - ADDR (+0x18), ADDR_MSB (+0x1C): read/write.
  - LENGTH (+0x28): LEN_WIDTH bits; upper bits read 0.
- Channel FSM: IDLE -> BUSY on an accepted LENGTH write with RS=1, idle, and nonzero written length. On that edge LENGTH updates; start pulses high the next cycle for one cycle; Idle clears. BUSY -> IDLE on done: Idle=1, IOC_Irq=1.
- LENGTH write rejected (Err set, LENGTH unchanged, no start) when RS=0, length=0, or channel BUSY.
- ADDR/ADDR_MSB writes while BUSY are ignored (outputs must stay stable).
- Clearing RS while BUSY: no abort; channel completes on done, then reports Halted.
- done while IDLE: ignored.
- Same-cycle IOC_Irq W1C and done: set wins.
- introut = IOC_Irq & IOC_IrqEn, registered (one-cycle latency). Clearing IrqEn masks without clearing IOC_Irq.
- Channels are independent and may be BUSY concurrently.
- Reset mid-transfer: immediate return to reset state; an in-flight AXI response is discarded; a subsequent done is ignored.

Test Plan:
- Reset, then read 0x04 and 0x34 -> 0x00000003 each (Halted|Idle). bvalid = rvalid = 0.
- Write 0x48=0xC0000000, 0x30=0x00001001, 0x58=0x40 -> s2mm_start single pulse with s2mm_addr=0x00000000C0000000, s2mm_len=0x40. Read 0x34 -> 0x0 (busy, running).
- Pulse s2mm_done -> s2mm_introut=1 next cycle; 0x34 reads 0x1002. Write 0x34=0x1000 -> introut=0, 0x34 reads 0x2.
- Same sequence on MM2S (0x18/0x00/0x28) concurrently with S2MM busy -> independent start/introut; no cross-channel effect.
- 0x28=0x40 with RS=0, then 0x28=0 with RS=1 -> no mm2s_start; 0x04 bit4=1; LENGTH unchanged.
- awvalid held 5 cycles before wvalid, and bready delayed 3 cycles -> no accept until both valids present; bvalid held until bready; next write not accepted while bvalid=1.

Source files
------------

// File: rtl/axil_dma_regs.sv
// AXI4-Lite register file for a two-channel (MM2S / S2MM) simple-mode DMA.
// Holds the CR/SR/ADDR/LENGTH registers, launches transfers and raises completion interrupts.
module axil_dma_regs #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 26
) (
    input  logic                    S_AXI_aclk,
    input  logic                    S_AXI_aresetn,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_awaddr,
    input  logic [2:0]              S_AXI_awprot,
    input  logic                    S_AXI_awvalid,
    output logic                    S_AXI_awready,
    input  logic [DATA_WIDTH-1:0]   S_AXI_wdata,
    input  logic [3:0]              S_AXI_wstrb,
    input  logic                    S_AXI_wvalid,
    output logic                    S_AXI_wready,
    output logic [1:0]              S_AXI_bresp,
    output logic                    S_AXI_bvalid,
    input  logic                    S_AXI_bready,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_araddr,
    input  logic [2:0]              S_AXI_arprot,
    input  logic                    S_AXI_arvalid,
    output logic                    S_AXI_arready,
    output logic [DATA_WIDTH-1:0]   S_AXI_rdata,
    output logic [1:0]              S_AXI_rresp,
    output logic                    S_AXI_rvalid,
    input  logic                    S_AXI_rready,
    output logic                    mm2s_start,
    output logic [63:0]             mm2s_addr,
    output logic [LEN_WIDTH-1:0]    mm2s_len,
    input  logic                    mm2s_done,
    output logic                    s2mm_start,
    output logic [63:0]             s2mm_addr,
    output logic [LEN_WIDTH-1:0]    s2mm_len,
    input  logic                    s2mm_done,
    output logic                    mm2s_introut,
    output logic                    s2mm_introut
);

    // Channel index 0 is MM2S (base 0x00), index 1 is S2MM (base 0x30).
    logic                        r_awready, r_bvalid, r_arready, r_rvalid;
    logic [31:0]                 r_rdata;
    logic [1:0]                  r_rs, r_ien, r_ioc, r_err, r_busy, r_start, r_intr;
    logic [1:0][31:0]            r_lo, r_hi;
    logic [1:0][LEN_WIDTH-1:0]   r_len;

    logic [7:0]           w_wr_off, w_wr_rel, w_rd_off, w_rd_rel;
    logic                 w_wr_ch, w_wr_map, w_rd_ch, w_rd_map, w_wr_en, w_rd_en;
    logic [31:0]          w_len_mrg, w_lo_mrg, w_hi_mrg, w_rd_data;
    logic [LEN_WIDTH-1:0] w_len_new;
    logic                 w_len_ok;
    logic [1:0]           w_done;
    logic                 w_unused;

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return res;
    endfunction

    assign w_unused = ^{S_AXI_awaddr[ADDR_WIDTH-1:8], S_AXI_araddr[ADDR_WIDTH-1:8],
                        S_AXI_awprot, S_AXI_arprot};

    assign w_wr_en  = r_awready & S_AXI_awvalid & S_AXI_wvalid;
    assign w_rd_en  = r_arready & S_AXI_arvalid;
    assign w_wr_off = S_AXI_awaddr[7:0];
    assign w_rd_off = S_AXI_araddr[7:0];
    assign w_wr_ch  = (w_wr_off >= 8'h30);
    assign w_rd_ch  = (w_rd_off >= 8'h30);
    assign w_wr_map = (w_wr_off < 8'h60);
    assign w_rd_map = (w_rd_off < 8'h60);
    assign w_wr_rel = w_wr_ch ? (w_wr_off - 8'h30) : w_wr_off;
    assign w_rd_rel = w_rd_ch ? (w_rd_off - 8'h30) : w_rd_off;
    assign w_done   = {s2mm_done, mm2s_done};

    // A LENGTH write is judged on the byte-merged value, not the raw bus data.
    assign w_len_mrg = f_merge({{(32-LEN_WIDTH){1'b0}}, r_len[w_wr_ch]}, S_AXI_wdata, S_AXI_wstrb);
    assign w_len_new = w_len_mrg[LEN_WIDTH-1:0];
    assign w_len_ok  = r_rs[w_wr_ch] & ~r_busy[w_wr_ch] & (w_len_new != {LEN_WIDTH{1'b0}});
    assign w_lo_mrg  = f_merge(r_lo[w_wr_ch], S_AXI_wdata, S_AXI_wstrb);
    assign w_hi_mrg  = f_merge(r_hi[w_wr_ch], S_AXI_wdata, S_AXI_wstrb);

    // Read-data decode for the currently presented read address.
    always_comb begin
        w_rd_data = 32'd0;
        if (w_rd_map) begin
            case (w_rd_rel)
                8'h00:   w_rd_data = {19'd0, r_ien[w_rd_ch], 11'd0, r_rs[w_rd_ch]};
                8'h04:   w_rd_data = {19'd0, r_ioc[w_rd_ch], 7'd0, r_err[w_rd_ch], 2'd0,
                                      ~r_busy[w_rd_ch], ~r_rs[w_rd_ch] & ~r_busy[w_rd_ch]};
                8'h18:   w_rd_data = r_lo[w_rd_ch];
                8'h1C:   w_rd_data = r_hi[w_rd_ch];
                8'h28:   w_rd_data = {{(32-LEN_WIDTH){1'b0}}, r_len[w_rd_ch]};
                default: w_rd_data = 32'd0;
            endcase
        end else begin
            w_rd_data = 32'd0;
        end
    end

    // AXI-Lite handshakes: one accept pulse per transaction, response held until taken.
    always_ff @(posedge S_AXI_aclk or negedge S_AXI_aresetn) begin
        if (!S_AXI_aresetn) begin
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= 32'd0;
        end else begin
            if (r_awready) begin
                r_awready <= 1'b0;
            end else if (S_AXI_awvalid && S_AXI_wvalid && !r_bvalid) begin
                r_awready <= 1'b1;
            end
            if (w_wr_en) begin
                r_bvalid <= 1'b1;
            end else if (S_AXI_bready) begin
                r_bvalid <= 1'b0;
            end
            if (r_arready) begin
                r_arready <= 1'b0;
            end else if (S_AXI_arvalid && !r_rvalid) begin
                r_arready <= 1'b1;
            end
            if (w_rd_en) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
            end else if (S_AXI_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // Per-channel registers and IDLE/BUSY state; done is applied last so its IOC set wins.
    always_ff @(posedge S_AXI_aclk or negedge S_AXI_aresetn) begin
        if (!S_AXI_aresetn) begin
            r_rs    <= 2'b00;
            r_ien   <= 2'b00;
            r_ioc   <= 2'b00;
            r_err   <= 2'b00;
            r_busy  <= 2'b00;
            r_start <= 2'b00;
            r_intr  <= 2'b00;
            r_lo    <= '0;
            r_hi    <= '0;
            r_len   <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                r_start[c] <= 1'b0;
                r_intr[c]  <= r_ioc[c] & r_ien[c];
                if (w_wr_en && w_wr_map && (w_wr_ch == 1'(c))) begin
                    case (w_wr_rel)
                        8'h00: begin
                            if (S_AXI_wstrb[0]) r_rs[c]  <= S_AXI_wdata[0];
                            if (S_AXI_wstrb[1]) r_ien[c] <= S_AXI_wdata[12];
                        end
                        8'h04: begin
                            if (S_AXI_wstrb[1] && S_AXI_wdata[12]) r_ioc[c] <= 1'b0;
                            if (S_AXI_wstrb[0] && S_AXI_wdata[4])  r_err[c] <= 1'b0;
                        end
                        8'h18: if (!r_busy[c]) r_lo[c] <= w_lo_mrg;
                        8'h1C: if (!r_busy[c]) r_hi[c] <= w_hi_mrg;
                        8'h28: begin
                            if (w_len_ok) begin
                                r_len[c]   <= w_len_new;
                                r_busy[c]  <= 1'b1;
                                r_start[c] <= 1'b1;
                            end else begin
                                r_err[c] <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                if (r_busy[c] && w_done[c]) begin
                    r_busy[c] <= 1'b0;
                    r_ioc[c]  <= 1'b1;
                end
            end
        end
    end

    assign S_AXI_awready = r_awready;
    assign S_AXI_wready  = r_awready;
    assign S_AXI_bvalid  = r_bvalid;
    assign S_AXI_bresp   = 2'b00;
    assign S_AXI_arready = r_arready;
    assign S_AXI_rvalid  = r_rvalid;
    assign S_AXI_rdata   = r_rdata;
    assign S_AXI_rresp   = 2'b00;
    assign mm2s_start    = r_start[0];
    assign s2mm_start    = r_start[1];
    assign mm2s_addr     = {r_hi[0], r_lo[0]};
    assign s2mm_addr     = {r_hi[1], r_lo[1]};
    assign mm2s_len      = r_len[0];
    assign s2mm_len      = r_len[1];
    assign mm2s_introut  = r_intr[0];
    assign s2mm_introut  = r_intr[1];

endmodule

// File: tb/tb_axil_dma_regs.sv
// Self-checking bench for axil_dma_regs: directed scenarios plus random register traffic
// compared against a behavioural register-map model.
module tb_axil_dma_regs;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic        mm2s_start, s2mm_start, mm2s_done, s2mm_done, mm2s_introut, s2mm_introut;
    logic [63:0] mm2s_addr, s2mm_addr;
    logic [25:0] mm2s_len, s2mm_len;

    axil_dma_regs dut (
        .S_AXI_aclk(clk), .S_AXI_aresetn(rst_n),
        .S_AXI_awaddr(awaddr), .S_AXI_awprot(awprot), .S_AXI_awvalid(awvalid), .S_AXI_awready(awready),
        .S_AXI_wdata(wdata), .S_AXI_wstrb(wstrb), .S_AXI_wvalid(wvalid), .S_AXI_wready(wready),
        .S_AXI_bresp(bresp), .S_AXI_bvalid(bvalid), .S_AXI_bready(bready),
        .S_AXI_araddr(araddr), .S_AXI_arprot(arprot), .S_AXI_arvalid(arvalid), .S_AXI_arready(arready),
        .S_AXI_rdata(rdata), .S_AXI_rresp(rresp), .S_AXI_rvalid(rvalid), .S_AXI_rready(rready),
        .mm2s_start(mm2s_start), .mm2s_addr(mm2s_addr), .mm2s_len(mm2s_len), .mm2s_done(mm2s_done),
        .s2mm_start(s2mm_start), .s2mm_addr(s2mm_addr), .s2mm_len(s2mm_len), .s2mm_done(s2mm_done),
        .mm2s_introut(mm2s_introut), .s2mm_introut(s2mm_introut)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: register contents per channel (0 = MM2S, 1 = S2MM).
    bit          m_rs[2], m_ien[2], m_ioc[2], m_err[2], m_busy[2];
    bit [31:0]   m_lo[2], m_hi[2], m_len[2];
    int          m_starts[2];

    // Observed start pulses, one count per high cycle.
    int          s_cnt[2];
    logic [63:0] s_addr[2];
    logic [31:0] s_len[2];

    always @(negedge clk) begin
        if (mm2s_start) begin s_cnt[0]++; s_addr[0] = mm2s_addr; s_len[0] = {6'd0, mm2s_len}; end
        if (s2mm_start) begin s_cnt[1]++; s_addr[1] = s2mm_addr; s_len[1] = {6'd0, s2mm_len}; end
    end

    function automatic bit [31:0] merge(input bit [31:0] o, input bit [31:0] d, input bit [3:0] s);
        bit [31:0] r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_rs[c] = 0; m_ien[c] = 0; m_ioc[c] = 0; m_err[c] = 0; m_busy[c] = 0;
            m_lo[c] = 0; m_hi[c] = 0; m_len[c] = 0;
        end
    endtask

    task automatic model_write(input bit [7:0] a, input bit [31:0] d, input bit [3:0] s);
        int c;
        bit [31:0] cr, nl;
        if (a >= 8'h60) return;
        c = (a >= 8'h30) ? 1 : 0;
        case (a - 8'(c * 8'h30))
            8'h00: begin
                cr = merge({19'd0, m_ien[c], 11'd0, m_rs[c]}, d, s);
                m_rs[c] = cr[0]; m_ien[c] = cr[12];
            end
            8'h04: begin
                if (s[1] && d[12]) m_ioc[c] = 0;
                if (s[0] && d[4])  m_err[c] = 0;
            end
            8'h18: if (!m_busy[c]) m_lo[c] = merge(m_lo[c], d, s);
            8'h1C: if (!m_busy[c]) m_hi[c] = merge(m_hi[c], d, s);
            8'h28: begin
                nl = merge(m_len[c], d, s) % (1 << 26);
                if (m_rs[c] && !m_busy[c] && nl != 0) begin
                    m_len[c] = nl; m_busy[c] = 1; m_starts[c]++;
                end else begin
                    m_err[c] = 1;
                end
            end
            default: ;
        endcase
    endtask

    function automatic bit [31:0] model_read(input bit [7:0] a);
        int c;
        if (a >= 8'h60) return 32'd0;
        c = (a >= 8'h30) ? 1 : 0;
        case (a - 8'(c * 8'h30))
            8'h00: return (m_ien[c] * 32'h1000) + m_rs[c];
            8'h04: return (m_ioc[c] * 32'h1000) + (m_err[c] * 32'h10) + ((!m_busy[c]) * 32'h2)
                          + ((!m_rs[c] && !m_busy[c]) ? 32'h1 : 32'h0);
            8'h18: return m_lo[c];
            8'h1C: return m_hi[c];
            8'h28: return m_len[c];
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_outputs();
        check("mm2s_starts", s_cnt[0], m_starts[0]);
        check("s2mm_starts", s_cnt[1], m_starts[1]);
        check("mm2s_introut", mm2s_introut, m_ioc[0] & m_ien[0]);
        check("s2mm_introut", s2mm_introut, m_ioc[1] & m_ien[1]);
        check("mm2s_addr", mm2s_addr, {m_hi[0], m_lo[0]});
        check("s2mm_addr", s2mm_addr, {m_hi[1], m_lo[1]});
        check("mm2s_len", mm2s_len, m_len[0]);
        check("s2mm_len", s2mm_len, m_len[1]);
    endtask

    task automatic wait_sig(ref logic sig, input string tag);
        int n = 0;
        while (sig !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        check(tag, sig, 1'b1);
    endtask

    task automatic axi_write(input bit [7:0] a, input bit [31:0] d, input bit [3:0] s);
        @(posedge clk); #1;
        awaddr = {24'd0, a}; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        wait_sig(awready, "awready");
        check("wready", wready, 1'b1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        model_write(a, d, s);
        wait_sig(bvalid, "bvalid");
        check("bresp", bresp, 2'b00);
        @(posedge clk); #1;
        bready = 1'b0;
        check_outputs();
    endtask

    task automatic axi_read(input bit [7:0] a, output bit [31:0] d);
        @(posedge clk); #1;
        araddr = {24'd0, a}; arvalid = 1'b1; rready = 1'b1;
        wait_sig(arready, "arready");
        @(posedge clk); #1;
        arvalid = 1'b0;
        wait_sig(rvalid, "rvalid");
        check("rresp", rresp, 2'b00);
        d = rdata;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic rd_exp(input bit [7:0] a, input bit [31:0] exp);
        bit [31:0] got;
        axi_read(a, got);
        check($sformatf("rd_%02h", a), got, exp);
    endtask

    task automatic pulse_done(input int c);
        @(posedge clk); #1;
        if (c == 0) mm2s_done = 1'b1; else s2mm_done = 1'b1;
        @(posedge clk); #1;
        mm2s_done = 1'b0; s2mm_done = 1'b0;
        if (m_busy[c]) begin m_busy[c] = 0; m_ioc[c] = 1; end
        @(posedge clk); #1;
        check_outputs();
    endtask

    bit [7:0] alist [13] = '{8'h00, 8'h04, 8'h18, 8'h1C, 8'h28, 8'h30, 8'h34,
                             8'h48, 8'h4C, 8'h58, 8'h08, 8'h60, 8'hFC};

    initial begin
        bit [7:0]  a;
        bit [31:0] d;
        bit [3:0]  s;
        int        op;

        rst_n = 1'b0;
        awaddr = 32'd0; wdata = 32'd0; araddr = 32'd0; awprot = 3'd0; arprot = 3'd0; wstrb = 4'd0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        mm2s_done = 1'b0; s2mm_done = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_awready", awready, 1'b0);
        check("rst_arready", arready, 1'b0);
        check_outputs();
        rst_n = 1'b1;
        rd_exp(8'h04, 32'h3);
        rd_exp(8'h34, 32'h3);

        // S2MM launch, completion, interrupt acknowledge.
        axi_write(8'h48, 32'hC000_0000, 4'hF);
        axi_write(8'h30, 32'h0000_1001, 4'hF);
        axi_write(8'h58, 32'h0000_0040, 4'hF);
        check("s2mm_start_cnt", s_cnt[1], 1);
        check("s2mm_start_addr", s_addr[1], 64'h0000_0000_C000_0000);
        check("s2mm_start_len", s_len[1], 32'h40);
        rd_exp(8'h34, 32'h0);
        pulse_done(1);
        check("s2mm_irq_on", s2mm_introut, 1'b1);
        rd_exp(8'h34, 32'h1002);
        axi_write(8'h34, 32'h0000_1000, 4'hF);
        check("s2mm_irq_off", s2mm_introut, 1'b0);
        rd_exp(8'h34, 32'h2);

        // MM2S while S2MM busy: independent starts and interrupts.
        axi_write(8'h58, 32'h0000_0080, 4'hF);
        axi_write(8'h18, 32'h0000_1000, 4'hF);
        axi_write(8'h00, 32'h0000_1001, 4'hF);
        axi_write(8'h28, 32'h0000_0020, 4'hF);
        check("mm2s_start_addr", s_addr[0], 64'h0000_0000_0000_1000);
        check("mm2s_start_len", s_len[0], 32'h20);
        rd_exp(8'h04, 32'h0);
        rd_exp(8'h34, 32'h0);
        pulse_done(0);
        check("mm2s_irq_on", mm2s_introut, 1'b1);
        check("s2mm_irq_quiet", s2mm_introut, 1'b0);
        rd_exp(8'h34, 32'h0);
        pulse_done(1);
        rd_exp(8'h34, 32'h1002);

        // Rejected LENGTH writes: RS clear, then zero length.
        axi_write(8'h00, 32'h0, 4'hF);
        axi_write(8'h28, 32'h40, 4'hF);
        axi_write(8'h00, 32'h1, 4'hF);
        axi_write(8'h28, 32'h0, 4'hF);
        rd_exp(8'h04, 32'h1012);
        rd_exp(8'h28, 32'h20);

        // Write handshake: lone awvalid, delayed bready, no accept while bvalid pending.
        @(posedge clk); #1;
        awaddr = 32'h1C; wdata = 32'h1234_5678; wstrb = 4'hF; awvalid = 1'b1; bready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("aw_alone", awready, 1'b0);
        end
        wvalid = 1'b1;
        wait_sig(awready, "awready_both");
        @(posedge clk); #1;
        model_write(8'h1C, 32'h1234_5678, 4'hF);
        awaddr = 32'h18; wdata = 32'hAAAA_0000; wstrb = 4'hF;
        for (int i = 0; i < 3; i++) begin
            check("bvalid_hold", bvalid, 1'b1);
            check("no_accept_pending", awready, 1'b0);
            @(posedge clk); #1;
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        wait_sig(awready, "awready_second");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        model_write(8'h18, 32'hAAAA_0000, 4'hF);
        bready = 1'b1;
        wait_sig(bvalid, "bvalid_second");
        @(posedge clk); #1;
        bready = 1'b0;
        rd_exp(8'h1C, model_read(8'h1C));
        rd_exp(8'h18, model_read(8'h18));

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 9);
            a = alist[$urandom_range(0, 12)];
            if (op < 5) begin
                d = $urandom;
                if (a == 8'h28 || a == 8'h58)
                    d = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 300));
                if (a == 8'h00 || a == 8'h30) d[0] = ($urandom_range(0, 3) != 0);
                s = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
                axi_write(a, d, s);
            end else if (op < 8) begin
                rd_exp(a, model_read(a));
            end else begin
                pulse_done($urandom_range(0, 1));
            end
        end

        // Reset mid-transfer, then a stray done.
        axi_write(8'h00, 32'h1001, 4'hF);
        axi_write(8'h28, 32'h10, 4'hF);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_len", mm2s_len, 26'd0);
        check("mid_rst_addr", mm2s_addr, 64'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        pulse_done(0);
        rd_exp(8'h04, 32'h3);
        rd_exp(8'h00, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
